// File: rtl/alu_seq.sv
// Sequential ALU with an accumulator register f, a registered carry flag and one-cycle done/err pulses.
// Optional macro ALU_SEQ_MUL_EN adds a WIDTH-cycle shift-add multiplier (s=111); otherwise s=111 raises err.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       s,
    input  logic             L,
    input  logic             En,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_ACC  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // Bit WIDTH of op_res carries the carry/borrow flag for the arithmetic ops.
    logic [WIDTH:0] op_res;

    always_comb begin
        op_res = '0;
        case (s)
            OP_ADD:  op_res = {1'b0, x} + {1'b0, y};
            OP_INC:  op_res = {1'b0, f} + {{WIDTH{1'b0}}, 1'b1};
            OP_SUB:  op_res = {1'b0, x} - {1'b0, y};
            OP_AND:  op_res = {1'b0, x & y};
            OP_OR:   op_res = {1'b0, x | y};
            OP_XOR:  op_res = {1'b0, x ^ y};
            OP_ACC:  op_res = {1'b0, f} + {1'b0, x};
            default: op_res = '0;
        endcase
    end

    assign zero = (f == '0);

`ifdef ALU_SEQ_MUL_EN

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     partial;
    logic [CW-1:0]      cnt;
    logic               mul_req;

    assign mul_req = En && !L && (s == OP_MUL);
    assign busy    = (state == MUL);

    // Low half of prod starts as the multiplier and is shifted out one bit per iteration.
    always_comb begin
        partial   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
        prod_step = {partial, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_req) state_next = MUL;
            MUL:     if (cnt == LAST_ITER) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            f     <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == MUL) begin
                prod <= prod_step;
                cnt  <= cnt + 1'b1;
                if (cnt == LAST_ITER) begin
                    f    <= prod_step[WIDTH-1:0];
                    cout <= |prod_step[2*WIDTH-1:WIDTH];
                    done <= 1'b1;
                end
            end else if (L) begin
                f    <= x;
                cout <= 1'b0;
            end else if (En) begin
                if (s == OP_MUL) begin
                    mcand <= x;
                    prod  <= {{WIDTH{1'b0}}, y};
                    cnt   <= '0;
                end else begin
                    f    <= op_res[WIDTH-1:0];
                    cout <= op_res[WIDTH];
                    done <= 1'b1;
                end
            end
        end
    end

`else

    assign busy = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            f    <= '0;
            cout <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (L) begin
                f    <= x;
                cout <= 1'b0;
            end else if (En) begin
                if (s == OP_MUL) begin
                    err <= 1'b1;
                end else begin
                    f    <= op_res[WIDTH-1:0];
                    cout <= op_res[WIDTH];
                    done <= 1'b1;
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=8); covers both builds of ALU_SEQ_MUL_EN.
module tb_alu_seq;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         L;
    logic         En;
    logic [2:0]   s;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] f;
    logic         cout;
    logic         zero;
    logic         busy;
    logic         done;
    logic         err;

    int nvec = 0;
    int nbad = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic       en;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ef;
        logic       ec;
        logic       eb;
        logic       ed;
        logic       ee;
    } vec_t;

    vec_t tbl[$];

    alu_seq #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .x(x),
        .y(y),
        .s(s),
        .L(L),
        .En(En),
        .f(f),
        .cout(cout),
        .zero(zero),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input string name, input logic rst, input logic ld, input logic en,
                                input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] ef, input logic ec, input logic eb,
                                input logic ed, input logic ee);
        vec_t v;
        v.name = name; v.rst = rst; v.ld = ld; v.en = en; v.op = op; v.a = a; v.b = b;
        v.ef = ef; v.ec = ec; v.eb = eb; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        reset = v.rst; L = v.ld; En = v.en; s = v.op; x = v.a; y = v.b;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        logic ez;
        ez = (v.ef == 8'd0);
        nvec++;
        if (f !== v.ef || cout !== v.ec || zero !== ez || busy !== v.eb || done !== v.ed || err !== v.ee) begin
            nbad++;
            $display("[TB] FAIL %s: got f=%0d cout=%0b zero=%0b busy=%0b done=%0b err=%0b, want f=%0d cout=%0b zero=%0b busy=%0b done=%0b err=%0b",
                     v.name, f, cout, zero, busy, done, err, v.ef, v.ec, ez, v.eb, v.ed, v.ee);
        end
    endtask

    task automatic runQueue();
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
        end
        tbl.delete();
    endtask

    initial begin
        reset = 1'b1; L = 1'b0; En = 1'b0; s = 3'b000; x = '0; y = '0;

        //           name          rst ld en op  x    y     f    c  b  d  e
        tbl.push_back(mk("reset0",    1, 0, 0, 0, 0,   0,    0,   0, 0, 0, 0));
        tbl.push_back(mk("load20",    0, 1, 0, 0, 20,  0,    20,  0, 0, 0, 0));
        tbl.push_back(mk("reset1",    1, 0, 0, 0, 0,   0,    0,   0, 0, 0, 0));
        tbl.push_back(mk("add_carry", 0, 0, 1, 0, 200, 100,  44,  1, 0, 1, 0));
        tbl.push_back(mk("hold_add",  0, 0, 0, 0, 1,   1,    44,  1, 0, 0, 0));
        tbl.push_back(mk("sub_borrow",0, 0, 1, 2, 20,  30,   246, 1, 0, 1, 0));
        tbl.push_back(mk("load253",   0, 1, 0, 0, 253, 0,    253, 0, 0, 0, 0));
        tbl.push_back(mk("inc254",    0, 0, 1, 1, 0,   0,    254, 0, 0, 1, 0));
        tbl.push_back(mk("inc255",    0, 0, 1, 1, 0,   0,    255, 0, 0, 1, 0));
        tbl.push_back(mk("inc_wrap",  0, 0, 1, 1, 0,   0,    0,   1, 0, 1, 0));
        tbl.push_back(mk("inc1",      0, 0, 1, 1, 0,   0,    1,   0, 0, 1, 0));
        tbl.push_back(mk("and",       0, 0, 1, 3, 8'hAA, 8'h55, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk("or",        0, 0, 1, 4, 8'hAA, 8'h55, 8'hFF, 0, 0, 1, 0));
        tbl.push_back(mk("xor",       0, 0, 1, 5, 8'hAA, 8'h55, 8'hFF, 0, 0, 1, 0));
        tbl.push_back(mk("acc_carry", 0, 0, 1, 6, 3,   0,    2,   1, 0, 1, 0));
        tbl.push_back(mk("sub_nob",   0, 0, 1, 2, 30,  20,   10,  0, 0, 1, 0));
        tbl.push_back(mk("load_prio", 0, 1, 1, 0, 7,   9,    7,   0, 0, 0, 0));
        tbl.push_back(mk("add_small", 0, 0, 1, 0, 1,   2,    3,   0, 0, 1, 0));
        tbl.push_back(mk("hold",      0, 0, 0, 0, 99,  77,   3,   0, 0, 0, 0));
        tbl.push_back(mk("sub_zero",  0, 0, 1, 2, 5,   5,    0,   0, 0, 1, 0));
        tbl.push_back(mk("rst_prio",  1, 1, 1, 0, 9,   9,    0,   0, 0, 0, 0));
        runQueue();

`ifdef ALU_SEQ_MUL_EN
        // Multiply 20*30 with x changed after the sampling edge and a competing request held through busy.
        tbl.push_back(mk("mul_pre",   0, 1, 0, 0, 5,   0,    5,   0, 0, 0, 0));
        tbl.push_back(mk("mul_start", 0, 0, 1, 7, 20,  30,   5,   0, 1, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk($sformatf("mul_busy%0d", i + 2), 0, 0, 1, 0, 40, 3, 5, 0, 1, 0, 0));
        tbl.push_back(mk("mul_done",  0, 0, 1, 0, 40,  3,    88,  1, 0, 1, 0));
        tbl.push_back(mk("post_mul",  0, 0, 1, 0, 40,  3,    43,  0, 0, 1, 0));
        runQueue();

        // Reset sampled during the 4th busy cycle aborts the multiply.
        tbl.push_back(mk("ab_pre",    0, 1, 0, 0, 9,   0,    9,   0, 0, 0, 0));
        tbl.push_back(mk("ab_start",  0, 0, 1, 7, 20,  30,   9,   0, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk($sformatf("ab_busy%0d", i + 2), 0, 0, 0, 0, 20, 30, 9, 0, 1, 0, 0));
        tbl.push_back(mk("ab_reset",  1, 0, 0, 0, 20,  30,   0,   0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk($sformatf("ab_quiet%0d", i), 0, 0, 0, 0, 20, 30, 0, 0, 0, 0, 0));
        runQueue();
`else
        // Without the multiplier, s=111 must raise err once and leave f/cout untouched.
        tbl.push_back(mk("nm_load20", 0, 1, 0, 0, 20,  0,    20,  0, 0, 0, 0));
        tbl.push_back(mk("nm_err",    0, 0, 1, 7, 5,   5,    20,  0, 0, 0, 1));
        tbl.push_back(mk("nm_clear",  0, 0, 0, 0, 5,   5,    20,  0, 0, 0, 0));
        tbl.push_back(mk("nm_add",    0, 0, 1, 0, 200, 100,  44,  1, 0, 1, 0));
        tbl.push_back(mk("nm_err_c",  0, 0, 1, 7, 3,   3,    44,  1, 0, 0, 1));
        tbl.push_back(mk("nm_err_c2", 0, 0, 1, 7, 3,   3,    44,  1, 0, 0, 1));
        tbl.push_back(mk("nm_hold",   0, 0, 0, 0, 3,   3,    44,  1, 0, 0, 0));
        runQueue();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
